// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one digit per slot, optional dead time,
// leading-zero suppression and a per-frame snapshot so the display never tears.
module fnd_scan_ctrl #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 125000,
  parameter int DEAD_CYCLES    = 1250,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     com,
  output logic [7:0]            seg_7,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_C  = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] COM_OFF = {DIGITS{COM_ACTIVE_LOW}};
  localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [4*DIGITS-1:0] value_reg;
  logic [DIGITS-1:0]   dp_reg, blank_reg;
  logic                lz_reg;
  logic [DIGITS-1:0]   com_reg, com_next;
  logic [7:0]          seg_reg, seg_next;
  logic                frame_start_reg;

  logic                take_snap;
  logic [4*DIGITS-1:0] value_eff;
  logic [DIGITS-1:0]   dp_eff, blank_eff;
  logic                lz_eff;
  logic [DIGITS-1:0]   zero_run, suppress;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  // The snapshot cycle itself already uses the live inputs, so digit 0 is
  // correct even when there is no dead time to hide the capture latency.
  assign take_snap = (cnt_reg == '0) && (idx_reg == '0);
  assign value_eff = take_snap ? value : value_reg;
  assign dp_eff    = take_snap ? dp    : dp_reg;
  assign blank_eff = take_snap ? blank : blank_reg;
  assign lz_eff    = take_snap ? lz_en : lz_reg;

  // zero_run[i]: digit i and every digit above it hold a zero nibble.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == DIGITS - 1) begin : g_top
        assign zero_run[gi] = (value_eff[4*gi +: 4] == 4'h0);
      end else begin : g_low
        assign zero_run[gi] = zero_run[gi+1] && (value_eff[4*gi +: 4] == 4'h0);
      end
      if (gi == 0) begin : g_d0
        assign suppress[gi] = 1'b0;
      end else begin : g_dn
        assign suppress[gi] = lz_eff && zero_run[gi];
      end
    end
  endgenerate

  always_comb begin
    cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    if (cnt_reg == CNT_MAX)
      idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + IDX_W'(1);
  end

  always_comb begin
    logic [3:0]        nib;
    logic              sel_dp, sel_blank, sel_sup;
    logic [DIGITS-1:0] com_on;
    logic [7:0]        seg_on;
    nib       = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_sup   = 1'b0;
    com_on    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        nib       = value_eff[4*i +: 4];
        sel_dp    = dp_eff[i];
        sel_blank = blank_eff[i];
        sel_sup   = suppress[i];
        com_on[i] = 1'b1;
      end
    end
    seg_on = {sel_dp && !sel_blank, (sel_blank || sel_sup) ? 7'h00 : decode(nib)};
    if (cnt_reg < DEAD_C) begin
      com_next = COM_OFF;
      seg_next = SEG_OFF;
    end else begin
      com_next = com_on ^ COM_OFF;
      seg_next = seg_on ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt_reg         <= '0;
      idx_reg         <= '0;
      value_reg       <= '0;
      dp_reg          <= '0;
      blank_reg       <= '0;
      lz_reg          <= 1'b0;
      com_reg         <= COM_OFF;
      seg_reg         <= SEG_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      com_reg         <= com_next;
      seg_reg         <= seg_next;
      frame_start_reg <= take_snap;
      if (take_snap) begin
        value_reg <= value;
        dp_reg    <= dp;
        blank_reg <= blank;
        lz_reg    <= lz_en;
      end
    end
  end

  assign com         = com_reg;
  assign seg_7       = seg_reg;
  assign frame_start = frame_start_reg;

endmodule
